// File: rtl/mcu_pkg.sv
// Shared encodings for the MCU control unit: FSM states, instruction fields, flag indices.
// Optional single-step input is enabled by defining MCU_SINGLE_STEP_EN.
package mcu_pkg;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_EXECUTE = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    localparam int unsigned IR_W = 12;

    // Instruction classes, ir[11:10]
    localparam logic [1:0] CLS_CTRL = 2'b00;
    localparam logic [1:0] CLS_ALU  = 2'b01;
    localparam logic [1:0] CLS_DATA = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    // Control sub-ops, ir[9:8]
    localparam logic [1:0] CTL_NOP = 2'b00;
    localparam logic [1:0] CTL_JMP = 2'b01;
    localparam logic [1:0] CTL_JZ  = 2'b10;
    localparam logic [1:0] CTL_JC  = 2'b11;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_S = 1;
    localparam int unsigned FLAG_O = 0;

    localparam int unsigned CLS_MSB  = 11;
    localparam int unsigned CLS_LSB  = 10;
    localparam int unsigned SUB_MSB  = 9;
    localparam int unsigned SUB_LSB  = 8;
    localparam int unsigned MODE_MSB = 7;
    localparam int unsigned MODE_LSB = 4;
    localparam int unsigned DEST_BIT = 8;
    localparam int unsigned ADDR_MSB = 3;
    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned IMM_LSB  = 0;

    typedef struct packed {
        logic alu;
        logic acc_from_alu;
        logic acc_from_imm;
        logic dmem_we;
        logic dmem_from_alu;
        logic sr_we;
        logic jump;
        logic halt;
    } exec_ctrl_t;

    // Side effects of the instruction held in ir, evaluated against the current sr.
    function automatic exec_ctrl_t decode_exec(input logic [IR_W-1:0] ir, input logic [3:0] sr);
        exec_ctrl_t c;
        c = '0;
        case (ir[CLS_MSB:CLS_LSB])
            CLS_CTRL: begin
                case (ir[SUB_MSB:SUB_LSB])
                    CTL_JMP: c.jump = 1'b1;
                    CTL_JZ:  c.jump = sr[FLAG_Z];
                    CTL_JC:  c.jump = sr[FLAG_C];
                    default: c.jump = 1'b0;
                endcase
            end
            CLS_ALU: begin
                c.alu   = 1'b1;
                c.sr_we = 1'b1;
                if (ir[DEST_BIT]) begin
                    c.dmem_we       = 1'b1;
                    c.dmem_from_alu = 1'b1;
                end else begin
                    c.acc_from_alu = 1'b1;
                end
            end
            CLS_DATA: begin
                if (ir[DEST_BIT]) c.dmem_we = 1'b1;
                else              c.acc_from_imm = 1'b1;
            end
            default: c.halt = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcu_data_mem.sv
// Data memory register file: asynchronous read, synchronous write, synchronous clear on rst.
// Single shared address for the read and write port.
module mcu_data_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    // Reset takes priority so a write pending in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mcu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit MCU; drives the ALU and owns PC/ACC/SR/DMEM.
// Define MCU_SINGLE_STEP_EN to add the `step` input that gates FETCH one instruction at a time.
module mcu_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned IMEM_AW    = 8,
    parameter int unsigned DMEM_DEPTH = 16
) (
`ifdef MCU_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [IR_W-1:0]    imem_rdata,
    output logic [7:0]         alu_op1,
    output logic [7:0]         alu_op2,
    output logic [3:0]         alu_mode,
    output logic               alu_en,
    input  logic [7:0]         alu_out,
    input  logic [3:0]         alu_cflags,
    output logic [7:0]         acc_out,
    output logic [3:0]         sr_out,
    output logic [IMEM_AW-1:0] pc_out,
    output logic               halted
);

    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    logic [1:0]         state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [7:0]         acc_q, acc_d;
    logic [3:0]         sr_q, sr_d;
    logic [IR_W-1:0]    ir_q, ir_d;

    logic               fetch_go;
    exec_ctrl_t         ctrl;
    logic               dmem_we;
    logic [7:0]         dmem_wdata;
    logic [7:0]         dmem_rdata;

`ifdef MCU_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign ctrl = decode_exec(ir_q, sr_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        sr_d       = sr_q;
        ir_d       = ir_q;
        dmem_we    = 1'b0;
        dmem_wdata = acc_q;
        case (state_q)
            ST_FETCH: begin
                if (fetch_go) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = imem_rdata;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + IMEM_AW'(1);
                if (ctrl.jump)         pc_d  = IMEM_AW'(ir_q[IMM_MSB:IMM_LSB]);
                if (ctrl.sr_we)        sr_d  = alu_cflags;
                if (ctrl.acc_from_alu) acc_d = alu_out;
                if (ctrl.acc_from_imm) acc_d = ir_q[IMM_MSB:IMM_LSB];
                dmem_we    = ctrl.dmem_we;
                dmem_wdata = ctrl.dmem_from_alu ? alu_out : acc_q;
                if (ctrl.halt) begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            acc_q   <= 8'h00;
            sr_q    <= 4'h0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            ir_q    <= ir_d;
        end
    end

    mcu_data_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DMEM_AW)
    ) u_data_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (dmem_we),
        .addr  (ir_q[DMEM_AW-1:0]),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign acc_out   = acc_q;
    assign sr_out    = sr_q;
    assign alu_op1   = acc_q;
    assign alu_op2   = dmem_rdata;
    assign alu_mode  = ir_q[MODE_MSB:MODE_LSB];
    assign alu_en    = (state_q == ST_EXECUTE) && ctrl.alu;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_mcu_control_unit.sv
// Directed bench for mcu_control_unit with a behavioural program memory and ALU.
// Expected values are queued at stimulus time and popped when the DUT output is sampled.
module tb_mcu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [11:0] imem_rdata = 12'h000;
    logic [7:0]  alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_mode, alu_cflags, sr_out;
    logic        alu_en, halted;
    logic [7:0]  acc_out, pc_out;
`ifdef MCU_SINGLE_STEP_EN
    logic        step;
`endif

    always #5 clk = ~clk;

    mcu_control_unit #(
        .IMEM_AW    (8),
        .DMEM_DEPTH (16)
    ) dut (
`ifdef MCU_SINGLE_STEP_EN
        .step       (step),
`endif
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_mode   (alu_mode),
        .alu_en     (alu_en),
        .alu_out    (alu_out),
        .alu_cflags (alu_cflags),
        .acc_out    (acc_out),
        .sr_out     (sr_out),
        .pc_out     (pc_out),
        .halted     (halted)
    );

    // Program memory: registered read, word valid one cycle after the address.
    logic [11:0] imem [256];
    always_ff @(posedge clk) imem_rdata <= imem[imem_addr];

    // Reference ALU: 0 add, 1 sub, otherwise and. Flags {Z,C,S,O}.
    logic [8:0] alu_wide;
    logic       alu_ovf;
    always_comb begin
        alu_wide = 9'h000;
        alu_ovf  = 1'b0;
        case (alu_mode)
            4'd0: begin
                alu_wide = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_ovf  = (alu_op1[7] == alu_op2[7]) && (alu_wide[7] != alu_op1[7]);
            end
            4'd1: begin
                alu_wide = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_ovf  = (alu_op1[7] != alu_op2[7]) && (alu_wide[7] != alu_op1[7]);
            end
            default: alu_wide = {1'b0, alu_op1 & alu_op2};
        endcase
    end
    assign alu_out    = alu_wide[7:0];
    assign alu_cflags = {alu_wide[7:0] == 8'h00, alu_wide[8], alu_wide[7], alu_ovf};

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_v(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 12'h000;
    endtask

    // One full instruction (FETCH, DECODE, EXECUTE) then compare architectural state.
    task automatic run_instr(input string tag, input logic [7:0] pc, input logic [7:0] acc,
                             input logic [3:0] sr);
        expect_v({tag, "_pc"}, 32'(pc));
        expect_v({tag, "_acc"}, 32'(acc));
        expect_v({tag, "_sr"}, 32'(sr));
        tick(3);
        check(32'(pc_out));
        check(32'(acc_out));
        check(32'(sr_out));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
`ifdef MCU_SINGLE_STEP_EN
        step = 1'b1;
`endif
        clear_imem();

        // Reset state
        do_reset();
        expect_v("rst_pc", 32'h0);
        expect_v("rst_acc", 32'h0);
        expect_v("rst_sr", 32'h0);
        expect_v("rst_imem_addr", 32'h0);
        expect_v("rst_alu_en", 32'h0);
        expect_v("rst_halted", 32'h0);
        check(32'(pc_out));
        check(32'(acc_out));
        check(32'(sr_out));
        check(32'(imem_addr));
        check(32'(alu_en));
        check(32'(halted));

        // ALU add path: LDI 5, STA [3], LDI 12, ADD [3], HALT
        imem[0] = 12'h805;
        imem[1] = 12'h903;
        imem[2] = 12'h80C;
        imem[3] = 12'h403;
        imem[4] = 12'hC00;
        do_reset();
        expect_v("fetch_alu_en", 32'h0);
        check(32'(alu_en));
        expect_v("add_op1", 32'd12);
        expect_v("add_op2", 32'd5);
        expect_v("add_mode", 32'd0);
        expect_v("add_en", 32'd1);
        tick(11);
        check(32'(alu_op1));
        check(32'(alu_op2));
        check(32'(alu_mode));
        check(32'(alu_en));
        expect_v("add_acc", 32'd17);
        expect_v("add_sr", 32'h0);
        expect_v("add_pc", 32'd4);
        expect_v("add_alu_en_off", 32'h0);
        tick(1);
        check(32'(acc_out));
        check(32'(sr_out));
        check(32'(pc_out));
        check(32'(alu_en));
        expect_v("halt_exec_halted", 32'h0);
        tick(2);
        check(32'(halted));
        expect_v("halt_halted", 32'h1);
        expect_v("halt_pc", 32'd4);
        tick(1);
        check(32'(halted));
        check(32'(pc_out));
        expect_v("halt_stay_halted", 32'h1);
        expect_v("halt_stay_pc", 32'd4);
        expect_v("halt_stay_acc", 32'd17);
        tick(6);
        check(32'(halted));
        check(32'(pc_out));
        check(32'(acc_out));

        // Branches, dmem-destination ALU op and PC wrap
        clear_imem();
        imem[8'h00] = 12'h800;  // LDI 0
        imem[8'h01] = 12'h401;  // ADD [1] -> 0, Z
        imem[8'h02] = 12'h240;  // JZ 0x40 taken
        imem[8'h40] = 12'h8FF;  // LDI 0xFF
        imem[8'h41] = 12'h902;  // STA [2]
        imem[8'h42] = 12'h802;  // LDI 2
        imem[8'h43] = 12'h402;  // ADD [2] -> 1, C
        imem[8'h44] = 12'h110;  // JMP 0x10
        imem[8'h10] = 12'h240;  // JZ not taken
        imem[8'h11] = 12'h320;  // JC 0x20 taken
        imem[8'h20] = 12'h505;  // ADD [5] -> dmem[5]
        imem[8'h21] = 12'h1FF;  // JMP 0xFF
        imem[8'hFF] = 12'h000;  // NOP, wraps
        do_reset();
        run_instr("ldi0", 8'h01, 8'h00, 4'h0);
        run_instr("add_zero", 8'h02, 8'h00, 4'h8);
        run_instr("jz_taken", 8'h40, 8'h00, 4'h8);
        run_instr("ldi_ff", 8'h41, 8'hFF, 4'h8);
        run_instr("sta2", 8'h42, 8'hFF, 4'h8);
        run_instr("ldi2", 8'h43, 8'h02, 4'h8);
        run_instr("add_carry", 8'h44, 8'h01, 4'h4);
        run_instr("jmp10", 8'h10, 8'h01, 4'h4);
        run_instr("jz_not_taken", 8'h11, 8'h01, 4'h4);
        run_instr("jc_taken", 8'h20, 8'h01, 4'h4);
        run_instr("alu_to_dmem", 8'h21, 8'h01, 4'h0);
        expect_v("dmem5_value", 32'h01);
        check(32'(alu_op2));
        run_instr("jmp_ff", 8'hFF, 8'h01, 4'h0);
        run_instr("nop_wrap", 8'h00, 8'h01, 4'h0);
        expect_v("wrap_imem_addr", 32'h00);
        check(32'(imem_addr));

        // Reset asserted in EXECUTE of an ALU op targeting dmem[3]
        clear_imem();
        imem[0] = 12'h880;  // LDI 0x80
        imem[1] = 12'h503;  // ADD [3] -> dmem[3], S
        do_reset();
        expect_v("pre_rst_acc", 32'h80);
        expect_v("pre_rst_en", 32'h1);
        tick(5);
        check(32'(acc_out));
        check(32'(alu_en));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_v("abort_pc", 32'h0);
        expect_v("abort_sr", 32'h0);
        expect_v("abort_acc", 32'h0);
        expect_v("abort_alu_en", 32'h0);
        expect_v("abort_imem_addr", 32'h0);
        check(32'(pc_out));
        check(32'(sr_out));
        check(32'(acc_out));
        check(32'(alu_en));
        check(32'(imem_addr));
        run_instr("rerun_ldi", 8'h01, 8'h80, 4'h0);
        expect_v("dmem3_cleared", 32'h00);
        expect_v("rerun_en", 32'h1);
        tick(2);
        check(32'(alu_op2));
        check(32'(alu_en));
        expect_v("rerun_sr", 32'h2);
        expect_v("rerun_acc", 32'h80);
        expect_v("dmem3_written", 32'h80);
        tick(1);
        check(32'(sr_out));
        check(32'(acc_out));
        check(32'(alu_op2));

`ifdef MCU_SINGLE_STEP_EN
        // Single step: FETCH holds while step is low
        do_reset();
        step = 1'b0;
        expect_v("step_hold_pc", 32'h0);
        expect_v("step_hold_acc", 32'h0);
        tick(10);
        check(32'(pc_out));
        check(32'(acc_out));
        step = 1'b1;
        tick(1);
        step = 1'b0;
        expect_v("step_one_pc", 32'h1);
        expect_v("step_one_acc", 32'h80);
        tick(2);
        check(32'(pc_out));
        check(32'(acc_out));
        expect_v("step_hold2_pc", 32'h1);
        tick(6);
        check(32'(pc_out));
        step = 1'b1;
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
